aoi_3_1: RTL and testbench
==========================

# aoi_3_1

Registered 10-input AND-OR-INVERT gate: Y = NOT((A·B·C) + (D·E·F) + (G·H·I·J)). Inputs and result pass through a two-stage valid-qualified pipeline, so the gate can sit on a clocked datapath without adding a combinational path. It also exports the three AND-term values for debug and coverage. It is a leaf cell in the microarchitecture logic library.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  qualifies A..J this cycle.
- A, B, C  in  1 each  AND term 0 operands.
- D, E, F  in  1 each  AND term 1 operands.
- G, H, I, J  in  1 each  AND term 2 operands.
- Y  out  1  registered AOI result.
- terms  out  3  registered AND-term values:
  - terms[0] = A·B·C
  - terms[1] = D·E·F
  - terms[2] = G·H·I·J
- out_valid  out  1  high for one cycle per accepted input, aligned with the Y/terms update.

## Operation
- Stage 1 (capture):
  - On a clk rising edge with in_valid=1, register A..J into s1_A..s1_J.
  - With in_valid=0, s1_* hold.
  - v1 <= in_valid every cycle.
- Stage 2 (evaluate):
  - On a clk rising edge with v1=1:
    - t0 = s1_A & s1_B & s1_C
    - t1 = s1_D & s1_E & s1_F
    - t2 = s1_G & s1_H & s1_I & s1_J
    - terms <= {t2, t1, t0}
    - Y <= ~(t0 | t1 | t2)
  - With v1=0, Y and terms hold.
  - out_valid <= v1 every cycle.
- All logic is 1-bit. There is no arithmetic and no state machine beyond the valid pipeline.
- Y=0 exactly when at least one term is fully asserted. Any partial term (e.g. F=1 alone) does not pull Y low.
- Reset (rst_n=0, asynchronous, takes effect immediately without a clock edge):
  - s1_* = 0, v1 = 0
  - Y = 1, terms = 3'b000, out_valid = 0
  - Y=1 is consistent with all-zero inputs.
- Reset mid-operation: in-flight samples are discarded. No out_valid pulse is produced for them after reset releases.
- Release of rst_n is sampled synchronously. The first edge with rst_n=1 may capture input.

## Timing
- Latency: 2 clk cycles. Input with in_valid=1 at edge N gives Y/terms/out_valid=1 visible after edge N+1.
- Throughput: one result per cycle. Back-to-back in_valid pulses give back-to-back out_valid pulses, each carrying its own input's result.
- No combinational path from any input to any output.
- No backpressure. Downstream must accept whenever out_valid=1.
- When in_valid drops, outputs hold their last computed values. out_valid deasserts 2 cycles after in_valid deasserts.

## Test plan
- Reset with all inputs 0: drive rst_n=0 asynchronously mid-cycle → Y=1, terms=000, out_valid=0 immediately, with no clock edge.
- After 100 ns of all-zero idle, apply F=1, G=1, others 0, with in_valid=1 → two edges later Y=1, terms=000, out_valid=1 for one cycle.
- Single full terms, each with in_valid=1 for one cycle:
  - A=B=C=1 → Y=0, terms=001
  - D=E=F=1 → Y=0, terms=010
  - G=H=I=J=1 → Y=0, terms=100
  - all 10 inputs = 1 → Y=0, terms=111
- Back-to-back stream over three consecutive cycles:
  - inputs: {A=B=C=1}, then all-0, then {G=H=I=J=1}
  - outputs on three consecutive cycles: Y=0, 1, 0; terms=001, 000, 100; out_valid=1 on all three.
- Hold behaviour: after a result Y=0, drive in_valid=0 and change inputs to all-0 → Y stays 0, out_valid=0.
- Reset mid-flight: assert in_valid with A=B=C=1, then pulse rst_n low before the second edge → Y=1 and out_valid stays 0 through the next 3 cycles after release.
- Exhaustive sweep: all 1024 input combinations streamed with in_valid=1 → each Y matches the reference expression 2 cycles later.

Source files
------------

// File: rtl/aoi_3_1.sv
// Registered 10-input AND-OR-INVERT gate, Y = ~(ABC + DEF + GHIJ), behind a
// two-stage valid-qualified pipeline that also exports the three AND terms.

package aoi_3_1_pkg;

  localparam int unsigned TERM_W = 3;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
    logic h;
    logic i;
    logic j;
  } aoi_ops_t;

endpackage : aoi_3_1_pkg

module aoi_3_1
  import aoi_3_1_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              A,
  input  logic              B,
  input  logic              C,
  input  logic              D,
  input  logic              E,
  input  logic              F,
  input  logic              G,
  input  logic              H,
  input  logic              I,
  input  logic              J,
  output logic              Y,
  output logic [TERM_W-1:0] terms,
  output logic              out_valid
);

  aoi_ops_t            ops_c;
  aoi_ops_t            s1_d;
  aoi_ops_t            s1_q;
  logic                v1_q;

  logic                t0_c;
  logic                t1_c;
  logic                t2_c;
  logic                y_d;
  logic                y_q;
  logic [TERM_W-1:0]   terms_d;
  logic [TERM_W-1:0]   terms_q;
  logic                out_valid_q;

  assign ops_c = {A, B, C, D, E, F, G, H, I, J};

  // Stage 1 operand capture: load on in_valid, otherwise hold
  always_comb begin
    s1_d = s1_q;
    if (in_valid) begin
      s1_d = ops_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      v1_q <= in_valid;
    end
  end

  // Stage 2 evaluation: terms and result update only for a valid stage-1 sample
  always_comb begin
    t0_c    = s1_q.a & s1_q.b & s1_q.c;
    t1_c    = s1_q.d & s1_q.e & s1_q.f;
    t2_c    = s1_q.g & s1_q.h & s1_q.i & s1_q.j;
    terms_d = terms_q;
    y_d     = y_q;
    if (v1_q) begin
      terms_d = {t2_c, t1_c, t0_c};
      y_d     = ~(t0_c | t1_c | t2_c);
    end
  end

  // Reset value Y=1 matches the gate output for all-zero operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q         <= 1'b1;
      terms_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      terms_q     <= terms_d;
      out_valid_q <= v1_q;
    end
  end

  assign Y         = y_q;
  assign terms     = terms_q;
  assign out_valid = out_valid_q;

endmodule : aoi_3_1

// File: tb/tb_aoi_3_1.sv
// Self-checking bench for aoi_3_1: vector table, exhaustive sweep and
// reset corner cases, with a result queue checked whenever out_valid fires.

module tb_aoi_3_1;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       A, B, C, D, E, F, G, H, I, J;
  logic       Y;
  logic [2:0] terms;
  logic       out_valid;

  int unsigned n_checks;
  int unsigned n_pass;

  logic [3:0] exp_q[$];

  typedef struct {
    logic [9:0] ops;
    logic       exp_y;
    logic [2:0] exp_terms;
    int         gap;
  } vec_t;

  vec_t vecs[8];

  aoi_3_1 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .E        (E),
    .F        (F),
    .G        (G),
    .H        (H),
    .I        (I),
    .J        (J),
    .Y        (Y),
    .terms    (terms),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
  endtask

  // Independent reference: ops[9]=A ... ops[0]=J; returns {Y, terms}
  function automatic logic [3:0] ref_model(input logic [9:0] ops);
    logic a, b, c, d, e, f, g, h, i, j;
    logic [2:0] t;
    {a, b, c, d, e, f, g, h, i, j} = ops;
    t[0] = a && b && c;
    t[1] = d && e && f;
    t[2] = g && h && i && j;
    return {!(t[0] || t[1] || t[2]), t};
  endfunction

  task automatic drive(input logic [9:0] ops, input logic val, input logic [3:0] exp);
    @(posedge clk);
    #1;
    {A, B, C, D, E, F, G, H, I, J} = ops;
    in_valid = val;
    if (val) exp_q.push_back(exp);
  endtask

  // Scoreboard: every out_valid pulse must match the oldest pending result
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {Y, terms}, 4'bxxxx);
      end else begin
        chk("result", {Y, terms}, exp_q.pop_front());
      end
    end
  end

  initial begin
    vecs[0] = '{10'b0000011000, 1'b1, 3'b000, 3};
    vecs[1] = '{10'b1110000000, 1'b0, 3'b001, 3};
    vecs[2] = '{10'b0001110000, 1'b0, 3'b010, 3};
    vecs[3] = '{10'b0000001111, 1'b0, 3'b100, 3};
    vecs[4] = '{10'b1111111111, 1'b0, 3'b111, 3};
    vecs[5] = '{10'b1110000000, 1'b0, 3'b001, 0};
    vecs[6] = '{10'b0000000000, 1'b1, 3'b000, 0};
    vecs[7] = '{10'b0000001111, 1'b0, 3'b100, 0};

    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    {A, B, C, D, E, F, G, H, I, J} = '0;

    // Asynchronous reset mid-cycle, observed before any clock edge
    #3 rst_n = 1'b0;
    #1;
    chk("reset_Y", {3'b000, Y}, 4'b0001);
    chk("reset_terms", {1'b0, terms}, 4'b0000);
    chk("reset_out_valid", {3'b000, out_valid}, 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      drive(vecs[k].ops, 1'b1, {vecs[k].exp_y, vecs[k].exp_terms});
      for (int g = 0; g < vecs[k].gap; g++) drive(10'b0, 1'b0, 4'b0);
    end

    // Hold: inputs change while in_valid=0, last result must persist
    drive(10'b0, 1'b0, 4'b0);
    repeat (4) @(negedge clk);
    chk("hold_result", {Y, terms}, 4'b0100);
    chk("hold_out_valid", {3'b000, out_valid}, 4'b0000);
    chk("hold_queue_drained", 4'(exp_q.size()), 4'd0);

    // Reset between capture and evaluate discards the in-flight sample
    drive(10'b1110000000, 1'b1, 4'b0001);
    @(posedge clk);
    #3 rst_n = 1'b0;
    exp_q.delete();
    in_valid = 1'b0;
    {A, B, C, D, E, F, G, H, I, J} = '0;
    #1;
    chk("midreset_Y", {3'b000, Y}, 4'b0001);
    chk("midreset_out_valid", {3'b000, out_valid}, 4'b0000);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_reset_out_valid", {3'b000, out_valid}, 4'b0000);
      chk("post_reset_Y", {3'b000, Y}, 4'b0001);
    end

    // Exhaustive back-to-back sweep of all 1024 operand patterns
    for (int v = 0; v < 1024; v++) begin
      drive(10'(v), 1'b1, ref_model(10'(v)));
    end
    drive(10'b0, 1'b0, 4'b0);
    repeat (4) @(negedge clk);
    chk("final_queue_drained", 4'(exp_q.size() > 15 ? 15 : exp_q.size()), 4'd0);
    chk("final_out_valid", {3'b000, out_valid}, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_aoi_3_1
